// File: rtl/prog_sequencer_pkg.sv
// Shared types and program start-address table for the program sequencer.
package prog_seq_pkg;

    localparam int unsigned DEF_PC_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [DEF_PC_W-1:0] START1 = 10'd0;
    localparam logic [DEF_PC_W-1:0] START2 = 10'd256;
    localparam logic [DEF_PC_W-1:0] START3 = 10'd512;

    function automatic logic [DEF_PC_W-1:0] start_pc(input logic [1:0] id);
        logic [DEF_PC_W-1:0] pc;
        case (id)
            2'd2:    pc = START2;
            2'd3:    pc = START3;
            default: pc = START1;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Request/acknowledge and core-control bundle between the bench/core side and the sequencer.
interface prog_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             req;
    logic             halt;
    logic             ack;
    logic             pc_load;
    logic [PC_W-1:0]  pc_start;
    logic             run;
    logic [1:0]       prog_id;
    logic [CNT_W-1:0] cycles;
    logic             timeout;

    modport master (
        output req, halt,
        input  ack, pc_load, pc_start, run, prog_id, cycles, timeout
    );

    modport slave (
        input  req, halt,
        output ack, pc_load, pc_start, run, prog_id, cycles, timeout
    );
endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter; at_limit flags that the next enabled edge reaches LIMIT.
module sat_counter #(
    parameter int unsigned   W     = 16,
    parameter logic [W-1:0]  LIMIT = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_limit
);
    localparam logic [W-1:0] LimitM1 = LIMIT - 1'b1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LimitM1);
endmodule

// File: rtl/prog_sequencer.sv
// Launches programs 1->2->3->1 on each accepted req, runs the core until halt or watchdog,
// then raises ack; all outputs registered.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned      PC_W  = 10,
    parameter int unsigned      CNT_W = 16,
    parameter logic [CNT_W-1:0] WDOG  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    prog_sequencer_if.slave   bus
);
    seq_state_t      state_q, state_d;
    logic            ack_q, ack_d;
    logic            pc_load_q, pc_load_d;
    logic            run_q, run_d;
    logic            timeout_q, timeout_d;
    logic [1:0]      prog_id_q, prog_id_d;
    logic [PC_W-1:0] pc_start_q, pc_start_d;
    logic [1:0]      next_id;
    logic            accept;
    logic            at_limit;
    logic            cnt_en;

    assign next_id = (prog_id_q == 2'd3) ? 2'd1 : prog_id_q + 2'd1;
    assign cnt_en  = (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        pc_load_d  = 1'b0;
        run_d      = run_q;
        timeout_d  = timeout_q;
        prog_id_d  = prog_id_q;
        pc_start_d = pc_start_q;
        accept     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.req) begin
                    accept     = 1'b1;
                    state_d    = LOAD;
                    ack_d      = 1'b0;
                    timeout_d  = 1'b0;
                    prog_id_d  = next_id;
                    pc_start_d = PC_W'(start_pc(next_id));
                    pc_load_d  = 1'b1;
                    run_d      = 1'b0;
                end
            end
            LOAD: begin
                state_d = RUN;
                run_d   = 1'b1;
            end
            RUN: begin
                // Halt has priority over a coincident watchdog expiry.
                if (bus.halt) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    run_d   = 1'b0;
                end else if (at_limit) begin
                    state_d   = DONE;
                    ack_d     = 1'b1;
                    run_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            pc_load_q  <= 1'b0;
            run_q      <= 1'b0;
            timeout_q  <= 1'b0;
            prog_id_q  <= 2'd0;
            pc_start_q <= PC_W'(START1);
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            pc_load_q  <= pc_load_d;
            run_q      <= run_d;
            timeout_q  <= timeout_d;
            prog_id_q  <= prog_id_d;
            pc_start_q <= pc_start_d;
        end
    end

    sat_counter #(
        .W     (CNT_W),
        .LIMIT (WDOG)
    ) u_cycles (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .en       (cnt_en),
        .count    (bus.cycles),
        .at_limit (at_limit)
    );

    assign bus.ack      = ack_q;
    assign bus.pc_load  = pc_load_q;
    assign bus.run      = run_q;
    assign bus.timeout  = timeout_q;
    assign bus.prog_id  = prog_id_q;
    assign bus.pc_start = pc_start_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed plus randomized bench for prog_sequencer against a program-level reference model.
module tb_prog_sequencer;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;
    localparam int          WD    = 16;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   model_id = 0;
    int   start_tbl [4] = '{0, 0, 256, 512};

    prog_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) sif ();

    prog_sequencer #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W),
        .WDOG  (16'(WD))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full program: accept, load, run until halt at RUN edge halt_at (0 = never).
    task automatic launch(input int halt_at, input bit noisy);
        int exp_id, exp_n, n;
        bit exp_to;
        exp_id = (model_id == 3) ? 1 : model_id + 1;
        exp_to = !(halt_at >= 1 && halt_at <= WD);
        exp_n  = exp_to ? WD : halt_at;
        sif.req  = 1'b1;
        sif.halt = noisy ? 1'($urandom % 2) : 1'b0;
        step();
        chk("acc_ack", sif.ack, 0);
        chk("acc_pc_load", sif.pc_load, 1);
        chk("acc_run", sif.run, 0);
        chk("acc_prog_id", sif.prog_id, exp_id);
        chk("acc_pc_start", sif.pc_start, start_tbl[exp_id]);
        chk("acc_cycles", sif.cycles, 0);
        chk("acc_timeout", sif.timeout, 0);
        model_id = exp_id;
        // req and halt during LOAD must be ignored
        sif.req  = noisy ? 1'($urandom % 2) : 1'b0;
        sif.halt = noisy ? 1'($urandom % 2) : 1'b0;
        step();
        chk("load_pc_load", sif.pc_load, 0);
        chk("load_run", sif.run, 1);
        n = 0;
        while (sif.ack !== 1'b1 && n < 40) begin
            n++;
            sif.halt = (n == halt_at);
            sif.req  = noisy ? 1'($urandom % 2) : 1'b0;
            step();
        end
        sif.req  = 1'b0;
        sif.halt = 1'b0;
        chk("run_len", n, exp_n);
        chk("done_ack", sif.ack, 1);
        chk("done_run", sif.run, 0);
        chk("done_cycles", sif.cycles, exp_n);
        chk("done_timeout", sif.timeout, exp_to);
        chk("done_prog_id", sif.prog_id, model_id);
    endtask

    initial begin
        reset    = 1'b1;
        sif.req  = 1'b0;
        sif.halt = 1'b0;
        step();
        step();
        chk("rst_ack", sif.ack, 0);
        chk("rst_pc_load", sif.pc_load, 0);
        chk("rst_run", sif.run, 0);
        chk("rst_prog_id", sif.prog_id, 0);
        chk("rst_cycles", sif.cycles, 0);
        chk("rst_timeout", sif.timeout, 0);
        chk("rst_pc_start", sif.pc_start, 0);
        reset = 1'b0;

        // halt in IDLE is ignored
        sif.halt = 1'b1;
        step();
        step();
        sif.halt = 1'b0;
        chk("idle_halt_ack", sif.ack, 0);
        chk("idle_halt_run", sif.run, 0);
        chk("idle_halt_prog", sif.prog_id, 0);

        launch(5, 1'b0);
        launch(3, 1'b1);
        launch(1, 1'b1);
        launch(7, 1'b1);
        launch(0, 1'b0);

        // halt in DONE is ignored
        sif.halt = 1'b1;
        step();
        step();
        sif.halt = 1'b0;
        chk("done_halt_ack", sif.ack, 1);
        chk("done_halt_prog", sif.prog_id, model_id);
        chk("done_halt_to", sif.timeout, 1);

        launch(2, 1'b0);

        // reset three cycles into RUN
        sif.req = 1'b1;
        step();
        sif.req = 1'b0;
        step();
        step();
        step();
        step();
        chk("mid_cycles", sif.cycles, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_id = 0;
        chk("mid_rst_run", sif.run, 0);
        chk("mid_rst_prog", sif.prog_id, 0);
        chk("mid_rst_ack", sif.ack, 0);
        launch(4, 1'b0);

        launch(WD, 1'b1);

        // req held four cycles: exactly one launch
        sif.req = 1'b1;
        repeat (4) step();
        sif.req = 1'b0;
        model_id = (model_id == 3) ? 1 : model_id + 1;
        chk("hold_prog", sif.prog_id, model_id);
        chk("hold_run", sif.run, 1);
        chk("hold_ack", sif.ack, 0);
        chk("hold_cycles", sif.cycles, 2);
        sif.halt = 1'b1;
        step();
        sif.halt = 1'b0;
        chk("hold_done_ack", sif.ack, 1);
        chk("hold_done_cycles", sif.cycles, 3);

        for (int i = 0; i < 20; i++) begin
            launch(int'($urandom_range(0, 20)), 1'($urandom % 2));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
